// File: rtl/mm_pkg.sv
// Shared types and helpers for the systolic matrix-multiply core.
// Latency helpers derive pipeline depths from mesh geometry.
// State enums for the ingress sequencer and the result readout.
package mm_pkg;

  // Cycles from operands at a PE input to the accumulator holding the product.
  function automatic int pe_lat(input int pipe_mul);
    return 1 + pipe_mul;
  endfunction

  // Cycles after the last beat until the far-corner PE has folded it in.
  function automatic int flush_cyc(input int r, input int c, input int pipe_mul);
    return r + c - 2 + pe_lat(pipe_mul);
  endfunction

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    FLUSH   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4
  } ing_state_e;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } egr_state_e;

endpackage

// File: rtl/pe.sv
// Processing element: multiply-accumulate with registered A/B pass-through.
// Latency: pass-through 1 cycle, product into accumulator 1+PIPE_MUL cycles.
// No backpressure; operands flow every cycle, valid gates accumulation.
module pe #(
  parameter int W        = 8,
  parameter int ACCW     = 32,
  parameter int SIGNED_M = 1,
  parameter int PIPE_MUL = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    a_in,
  input  logic            a_vld_in,
  input  logic [W-1:0]    b_in,
  input  logic            b_vld_in,
  input  logic            acc_clear_block,
  input  logic            drain,
  output logic [W-1:0]    a_out,
  output logic            a_vld_out,
  output logic [W-1:0]    b_out,
  output logic            b_vld_out,
  output logic [ACCW-1:0] acc_out
);

  logic [ACCW-1:0] prod;
  logic [ACCW-1:0] mac_prod;
  logic            mac_vld;
  logic [ACCW-1:0] acc_d, acc_q;
  logic [W-1:0]    a_q, b_q;
  logic            av_q, bv_q;

  // Product extended to accumulator width; wraps naturally mod 2^ACCW.
  always_comb begin
    if (SIGNED_M != 0) prod = ACCW'($signed(a_in)) * ACCW'($signed(b_in));
    else               prod = ACCW'(a_in) * ACCW'(b_in);
  end

  generate
    if (PIPE_MUL != 0) begin : g_pipe
      logic [ACCW-1:0] prod_q;
      logic            pv_q;
      // Optional product register to break the multiplier path.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prod_q <= '0;
          pv_q   <= 1'b0;
        end else begin
          prod_q <= prod;
          pv_q   <= a_vld_in & b_vld_in;
        end
      end
      assign mac_prod = prod_q;
      assign mac_vld  = pv_q;
    end else begin : g_comb
      assign mac_prod = prod;
      assign mac_vld  = a_vld_in & b_vld_in;
    end
  endgenerate

  // Block clear wins over accumulation; drain holds the accumulator.
  always_comb begin
    acc_d = acc_q;
    if (acc_clear_block)        acc_d = '0;
    else if (mac_vld && !drain) acc_d = acc_q + mac_prod;
  end

  // Accumulator and neighbour pass-through registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      av_q  <= 1'b0;
      bv_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q   <= a_in;
      b_q   <= b_in;
      av_q  <= a_vld_in;
      bv_q  <= b_vld_in;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = av_q;
  assign b_out     = b_q;
  assign b_vld_out = bv_q;
  assign acc_out   = acc_q;

endmodule

// File: rtl/skew_delay.sv
// Fixed-depth delay line used to skew one mesh edge lane (data plus valid).
// Latency: D cycles; D=0 is a plain wire.
// No backpressure; shifts every cycle.
module skew_delay #(
  parameter int D  = 0,
  parameter int WD = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout
);

  generate
    if (D == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [WD-1:0] stage_d [D];
      logic [WD-1:0] stage_q [D];

      // Next value of each stage is its upstream neighbour.
      always_comb begin
        stage_d[0] = din;
        for (int k = 1; k < D; k++) stage_d[k] = stage_q[k-1];
      end

      // Shift register, cleared so no stale valid leaks after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) stage_q[k] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[D-1];
    end
  endgenerate

endmodule

// File: rtl/pe_array_stream.sv
// R x C systolic matmul: skewed ingress, block sequencing, shadowed row readout.
// Latency: last beat at t -> first result row at t + flush_cyc + 2 (shadow empty).
// in_ready drops from last beat until capture; out rows hold while !out_ready.
module pe_array_stream
  import mm_pkg::*;
#(
  parameter int W        = 8,
  parameter int ACCW     = 32,
  parameter int R        = 4,
  parameter int C        = 4,
  parameter int SIGNED_M = 1,
  parameter int PIPE_MUL = 0,
  localparam int RW      = (R > 1) ? $clog2(R) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R-1:0][W-1:0]   a_in,
  input  logic [C-1:0][W-1:0]   b_in,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [C-1:0][ACCW-1:0] out_data,
  output logic [RW-1:0]         out_row,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int FLUSH_CYC = flush_cyc(R, C, PIPE_MUL);
  localparam int CW        = $clog2(FLUSH_CYC + 1);

  ing_state_e ing_d, ing_q;
  egr_state_e egr_d, egr_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [RW-1:0] row_d, row_q;
  logic [C-1:0][ACCW-1:0] shadow_d [R];
  logic [C-1:0][ACCW-1:0] shadow_q [R];

  logic accept, capture, out_hs, last_row, shadow_free, shadow_avail, pe_rst_n;

  assign in_ready     = !rst && (ing_q == IDLE || ing_q == FEED);
  assign accept       = in_valid && in_ready;
  assign capture      = (ing_q == CAPTURE);
  assign out_valid    = (egr_q == STREAM);
  assign last_row     = (row_q == RW'(R - 1));
  assign out_hs       = out_valid && out_ready;
  assign shadow_free  = out_hs && last_row;
  assign shadow_avail = (egr_q == EMPTY) || shadow_free;
  assign out_last     = out_valid && last_row;
  assign out_row      = row_q;
  assign out_data     = shadow_q[row_q];
  assign busy         = (ing_q != IDLE) || (egr_q == STREAM);
  assign pe_rst_n     = ~rst;

  // Mesh wiring: A flows right along rows, B flows down along columns.
  logic [W-1:0]    a_h  [R][C+1];
  logic            av_h [R][C+1];
  logic [W-1:0]    b_v  [R+1][C];
  logic            bv_v [R+1][C];
  logic [ACCW-1:0] acc_w [R][C];
  logic [W:0]      a_sk [R];
  logic [W:0]      b_sk [C];

  genvar gi, gj;
  generate
    for (gi = 0; gi < R; gi++) begin : g_askew
      skew_delay #(.D(gi), .WD(W + 1)) u_skew (
        .clk (clk), .rst (rst), .din ({accept, a_in[gi]}), .dout (a_sk[gi])
      );
      assign a_h[gi][0]  = a_sk[gi][W-1:0];
      assign av_h[gi][0] = a_sk[gi][W];
    end
    for (gj = 0; gj < C; gj++) begin : g_bskew
      skew_delay #(.D(gj), .WD(W + 1)) u_skew (
        .clk (clk), .rst (rst), .din ({accept, b_in[gj]}), .dout (b_sk[gj])
      );
      assign b_v[0][gj]  = b_sk[gj][W-1:0];
      assign bv_v[0][gj] = b_sk[gj][W];
    end
    for (gi = 0; gi < R; gi++) begin : g_row
      for (gj = 0; gj < C; gj++) begin : g_col
        pe #(.W(W), .ACCW(ACCW), .SIGNED_M(SIGNED_M), .PIPE_MUL(PIPE_MUL)) u_pe (
          .clk             (clk),
          .rst_n           (pe_rst_n),
          .a_in            (a_h[gi][gj]),
          .a_vld_in        (av_h[gi][gj]),
          .b_in            (b_v[gi][gj]),
          .b_vld_in        (bv_v[gi][gj]),
          .acc_clear_block (capture),
          .drain           (1'b0),
          .a_out           (a_h[gi][gj+1]),
          .a_vld_out       (av_h[gi][gj+1]),
          .b_out           (b_v[gi+1][gj]),
          .b_vld_out       (bv_v[gi+1][gj]),
          .acc_out         (acc_w[gi][gj])
        );
      end
    end
  endgenerate

  // Ingress sequencing: accept beats, wait for the wavefront to drain, capture.
  always_comb begin
    ing_d = ing_q;
    cnt_d = cnt_q;
    case (ing_q)
      IDLE, FEED: begin
        if (accept) begin
          ing_d = in_last ? FLUSH : FEED;
          if (in_last) cnt_d = CW'(FLUSH_CYC - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == '0) ing_d = shadow_avail ? CAPTURE : WAIT;
        else             cnt_d = cnt_q - 1'b1;
      end
      WAIT:    if (shadow_avail) ing_d = CAPTURE;
      CAPTURE: ing_d = IDLE;
      default: ing_d = IDLE;
    endcase
  end

  // Egress: a capture fills the shadow; rows advance on each handshake.
  always_comb begin
    egr_d    = egr_q;
    row_d    = row_q;
    shadow_d = shadow_q;
    if (capture) begin
      egr_d = STREAM;
      row_d = '0;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++) shadow_d[i][j] = acc_w[i][j];
    end else if (out_hs) begin
      if (last_row) begin
        egr_d = EMPTY;
        row_d = '0;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  // State, counters and the shadow buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ing_q <= IDLE;
      egr_q <= EMPTY;
      cnt_q <= '0;
      row_q <= '0;
      for (int i = 0; i < R; i++) shadow_q[i] <= '0;
    end else begin
      ing_q    <= ing_d;
      egr_q    <= egr_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_pe_array_stream.sv
// Directed bench for pe_array_stream: a 4x3 signed core and a 2x2 unsigned core.
// Latency, ordering, stall freezing, back-to-back blocks and reset are covered.
// Drives after the rising edge, samples on the falling edge.
module tb_pe_array_stream;

  localparam int W    = 8;
  localparam int R    = 4;
  localparam int C    = 3;
  localparam int ACCW = 32;
  localparam int F    = R + C - 2 + 1;
  localparam int F2   = 2 + 2 - 2 + 1;
  localparam int MAXK = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4x3 signed instance
  logic [R-1:0][W-1:0]    a_in;
  logic [C-1:0][W-1:0]    b_in;
  logic                   in_valid, in_last, in_ready;
  logic [C-1:0][ACCW-1:0] out_data;
  logic [1:0]             out_row;
  logic                   out_valid, out_last, out_ready, busy;

  pe_array_stream #(.W(W), .ACCW(ACCW), .R(R), .C(C), .SIGNED_M(1), .PIPE_MUL(0)) dut (
    .clk (clk), .rst (rst), .a_in (a_in), .b_in (b_in), .in_valid (in_valid),
    .in_last (in_last), .in_ready (in_ready), .out_data (out_data), .out_row (out_row),
    .out_valid (out_valid), .out_last (out_last), .out_ready (out_ready), .busy (busy)
  );

  // 2x2 unsigned instance with a 16-bit accumulator
  logic [1:0][W-1:0]  a2_in, b2_in;
  logic               in2_valid, in2_last, in2_ready;
  logic [1:0][15:0]   out2_data;
  logic [0:0]         out2_row;
  logic               out2_valid, out2_last, out2_ready, busy2;

  pe_array_stream #(.W(W), .ACCW(16), .R(2), .C(2), .SIGNED_M(0), .PIPE_MUL(0)) dut2 (
    .clk (clk), .rst (rst), .a_in (a2_in), .b_in (b2_in), .in_valid (in2_valid),
    .in_last (in2_last), .in_ready (in2_ready), .out_data (out2_data), .out_row (out2_row),
    .out_valid (out2_valid), .out_last (out2_last), .out_ready (out2_ready), .busy (busy2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int k;
    logic [MAXK-1:0][R-1:0][W-1:0] a;
    logic [MAXK-1:0][C-1:0][W-1:0] b;
    bit bubbles;
    int stall;
  } vec_t;

  vec_t vt[5];

  // Golden A*B for one element, two's-complement wrap at 32 bits.
  function automatic logic [ACCW-1:0] gold(input vec_t v, input int i, input int j);
    int s;
    logic signed [W-1:0] x, y;
    s = 0;
    for (int k = 0; k < v.k; k++) begin
      x = v.a[k][i];
      y = v.b[k][j];
      s += int'(x) * int'(y);
    end
    return ACCW'(s);
  endfunction

  // Presents each beat until accepted; optional bubbles carry a stray in_last.
  task automatic feed_block(input vec_t v, output int t_acc);
    bit acc;
    int n;
    t_acc = 0;
    @(posedge clk); #1;
    for (int k = 0; k < v.k; k++) begin
      if (v.bubbles) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_last = 1'b1; a_in = '1; b_in = '1;
          @(posedge clk); #1;
        end
      end
      a_in = v.a[k]; b_in = v.b[k]; in_valid = 1'b1; in_last = (k == v.k - 1);
      acc = 1'b0; n = 0;
      while (!acc && n < 300) begin
        @(negedge clk);
        acc = in_ready;
        t_acc = cyc;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) check("feed_accept_timeout", acc, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Waits for the block, optionally stalls, then takes all R rows back to back.
  task automatic collect(input vec_t v, input int t_acc, input bit chk_lat);
    logic [C-1:0][ACCW-1:0] exp_row;
    int n;
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", out_valid, 1);
    if (chk_lat) check("first_valid_cycle", cyc, t_acc + F + 2);
    for (int j = 0; j < C; j++) exp_row[j] = gold(v, 0, j);
    for (int s = 0; s < v.stall; s++) begin
      check("stall_valid", out_valid, 1);
      check("stall_row", out_row, 0);
      check("stall_data", out_data, exp_row);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) begin
      for (int j = 0; j < C; j++) exp_row[j] = gold(v, r, j);
      check("row_valid", out_valid, 1);
      check("row_index", out_row, r);
      check("row_last", out_last, (r == R - 1));
      check("row_data", out_data, exp_row);
      @(negedge clk);
    end
    check("no_extra_row", out_valid, 0);
    out_ready = 1'b0;
  endtask

  // Single beat into the 2x2 core; returns the accept cycle.
  task automatic feed2(input logic [W-1:0] a0, a1, b0, b1, input bit last, output int t);
    bit acc;
    int n;
    a2_in[0] = a0; a2_in[1] = a1; b2_in[0] = b0; b2_in[1] = b1;
    in2_valid = 1'b1; in2_last = last;
    acc = 1'b0; n = 0; t = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in2_ready;
      t = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("feed2_accept_timeout", acc, 1);
    in2_valid = 1'b0; in2_last = 1'b0;
  endtask

  task automatic wait2_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out2_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dut2_valid_timeout", out2_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [C-1:0][ACCW-1:0] ones_row;

    // Vector table: random signed with bubbles, same with a stall,
    // 0x80 squared, and a small hand pattern with negative B.
    for (int v = 0; v < 5; v++) begin
      vt[v].a = '0; vt[v].b = '0; vt[v].bubbles = 1'b0; vt[v].stall = 0;
    end
    vt[0].k = 5; vt[0].bubbles = 1'b1;
    vt[1].k = 5; vt[1].bubbles = 1'b1; vt[1].stall = 10;
    for (int v = 0; v < 2; v++)
      for (int k = 0; k < 5; k++) begin
        for (int i = 0; i < R; i++) vt[v].a[k][i] = 8'($urandom_range(0, 255));
        for (int j = 0; j < C; j++) vt[v].b[k][j] = 8'($urandom_range(0, 255));
      end
    vt[2].k = 1;
    for (int i = 0; i < R; i++) vt[2].a[0][i] = 8'h80;
    for (int j = 0; j < C; j++) vt[2].b[0][j] = 8'h80;
    vt[3].k = 3;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < R; i++) vt[3].a[k][i] = 8'(k + i + 1);
      for (int j = 0; j < C; j++) vt[3].b[k][j] = 8'(j - k);
    end
    vt[4].k = 1;
    for (int i = 0; i < R; i++) vt[4].a[0][i] = 8'd1;
    for (int j = 0; j < C; j++) vt[4].b[0][j] = 8'd1;

    rst = 1'b1;
    a_in = '0; b_in = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    a2_in = '0; b2_in = '0; in2_valid = 1'b0; in2_last = 1'b0; out2_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_row", out_row, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_in2_ready", in2_ready, 1);

    // 2x2: A=[[1,2],[3,4]] times identity, beats are columns of A / rows of B.
    @(posedge clk); #1;
    feed2(8'd1, 8'd3, 8'd1, 8'd0, 1'b0, t);
    feed2(8'd2, 8'd4, 8'd0, 8'd1, 1'b1, t);
    wait2_valid();
    check("id_first_valid_cycle", cyc, t + F2 + 2);
    check("id_row0", {out2_row, out2_last, out2_data}, {1'b0, 1'b0, 16'd2, 16'd1});
    @(negedge clk);
    check("id_row1", {out2_valid, out2_row, out2_last, out2_data}, {1'b1, 1'b1, 1'b1, 16'd4, 16'd3});
    @(negedge clk);
    check("id_done", out2_valid, 0);

    // 2x2 unsigned, K=1, 0x80 * 0x80.
    @(posedge clk); #1;
    feed2(8'h80, 8'h80, 8'h80, 8'h80, 1'b1, t);
    wait2_valid();
    check("u80_row0", out2_data, {16'h4000, 16'h4000});
    @(negedge clk);
    check("u80_row1", {out2_last, out2_data}, {1'b1, 16'h4000, 16'h4000});

    // Table-driven blocks on the 4x3 core.
    for (int v = 0; v < 4; v++) begin
      feed_block(vt[v], t);
      collect(vt[v], t, 1'b1);
    end

    // Back-to-back: second block must wait behind a full shadow.
    out_ready = 1'b0;
    feed_block(vt[3], t);
    feed_block(vt[0], t);
    repeat (F + 4) @(posedge clk);
    @(negedge clk);
    check("b2b_in_ready_low", in_ready, 0);
    check("b2b_busy", busy, 1);
    check("b2b_first_waiting", {out_valid, out_row}, {1'b1, 2'd0});
    collect(vt[3], 0, 1'b0);
    collect(vt[0], 0, 1'b0);

    // Reset in the middle of streaming discards the block.
    feed_block(vt[3], t);
    out_ready = 1'b0;
    while (!out_valid && cyc < 90000) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    check("pre_rst_row", out_row, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_state", {out_row, out_data, busy, in_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    feed_block(vt[4], t);
    collect(vt[4], t, 1'b1);
    for (int j = 0; j < C; j++) ones_row[j] = 32'd1;
    check("ones_gold", {gold(vt[4], 0, 0), gold(vt[4], R - 1, C - 1)}, {32'd1, 32'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
